// File: rtl/adc_scanner_if.sv
// adc_scanner_if: 24-bit command/result channel pair between a host and adc_scanner.
//   in_data  [23:16] opcode, [15:0] argument
//   in_wr    one-cycle command strobe
//   out_data [23] scan, [22] overrun, [18:16] channel, [15:0] result
//   out_wr   result valid, held until out_ack
//   out_ack  consumer accepts out_data in any cycle with out_wr=1
interface adc_scanner_if;
  logic [23:0] in_data;
  logic        in_wr;
  logic [23:0] out_data;
  logic        out_wr;
  logic        out_ack;

  modport master (output in_data, in_wr, out_ack, input out_data, out_wr);
  modport slave  (input in_data, in_wr, out_ack, output out_data, out_wr);
endinterface

// File: rtl/adc_scanner.sv
// adc_scanner: MCP3008-style SPI ADC front end with host single conversions and
// an autonomous averaged channel scan at a programmable period.
//   clk, rst_n        system clock, async active-low reset
//   adc_cs/clk/di/do  SPI mode 0 pins (CS active low, SCLK idles low)
//   host              command/result channel (adc_scanner_if.slave)
//   busy              frame, gap or pending single in progress
module adc_scanner #(
  parameter int CHANNELS = 8,
  parameter int DIV      = 5,
  parameter int AVG_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         adc_cs,
  output logic         adc_clk,
  output logic         adc_di,
  input  logic         adc_do,
  output logic         busy,
  adc_scanner_if.slave host
);
  localparam int ACC_W = 10 + AVG_LOG2;
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int DIV_W = $clog2(DIV);
  localparam int GAP_W = $clog2(2 * DIV);

  typedef enum logic [2:0] {IDLE, SHIFT, GAP, ACCUM, WAIT_PERIOD} state_t;

  state_t                state, state_n;
  logic [DIV_W-1:0]      div_cnt;
  logic [5:0]            half;
  logic [GAP_W-1:0]      gap_cnt;
  logic [9:0]            sr;
  logic [5:0]            mosi;
  logic [2:0]            cur_ch;
  logic                  cur_scan;
  logic                  pend_vld;
  logic [2:0]            pend_ch;
  logic [CHANNELS-1:0]   mask;
  logic [15:0]           period;
  logic [15:0]           tmr;
  logic [2:0]            ptr;
  logic [ACC_W-1:0]      acc;
  logic [SMP_W-1:0]      smp_cnt;
  logic                  ovr;
  logic [23:0]           out_data_q;
  logic                  out_wr_q;

  // command decode
  logic [7:0] op;
  logic       cmd_single, single_req;
  logic [2:0] single_ch;
  assign op         = host.in_data[23:16];
  assign cmd_single = host.in_wr && (op == 8'h00);
  assign single_req = cmd_single || pend_vld;
  // a fresh single overrides an older pending one
  assign single_ch  = cmd_single ? host.in_data[2:0] : pend_ch;

  // channel selection: next set bit above ptr, else wrap to lowest set bit
  logic [7:0] mask8;
  logic [2:0] lo_ch, up_ch, nxt_ch, scan_ch;
  logic       up_found, nxt_wrap;
  assign mask8 = 8'(mask);
  always_comb begin
    lo_ch    = '0;
    up_ch    = '0;
    up_found = 1'b0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (mask[c]) begin
        lo_ch = 3'(c);
        if (c > int'(ptr)) begin
          up_ch    = 3'(c);
          up_found = 1'b1;
        end
      end
    end
  end
  assign nxt_ch   = up_found ? up_ch : lo_ch;
  assign nxt_wrap = !up_found;
  // if the current channel was dropped from the mask, move on (and discard)
  assign scan_ch  = mask8[ptr] ? ptr : nxt_ch;

  logic tick, grp_done, pub;
  logic [ACC_W-1:0] acc_sum, avg_full;
  logic [9:0]       pub_res;
  assign tick     = (div_cnt == DIV_W'(DIV - 1));
  assign grp_done = (smp_cnt == SMP_W'((1 << AVG_LOG2) - 1));
  assign acc_sum  = acc + ACC_W'(sr);
  assign avg_full = acc_sum >> AVG_LOG2;
  assign pub_res  = cur_scan ? avg_full[9:0] : sr;
  assign pub      = (state == GAP && gap_cnt == '0 && !cur_scan) ||
                    (state == ACCUM && grp_done);

  // next state and frame start
  logic       start, start_scan;
  logic [2:0] start_ch;
  always_comb begin
    state_n    = state;
    start      = 1'b0;
    start_scan = 1'b0;
    start_ch   = single_ch;
    unique case (state)
      IDLE, WAIT_PERIOD: begin
        if (single_req) begin
          start   = 1'b1;
          state_n = SHIFT;
        end else if (mask != '0 && tmr == '0) begin
          start      = 1'b1;
          start_scan = 1'b1;
          start_ch   = scan_ch;
          state_n    = SHIFT;
        end else if (mask == '0) begin
          state_n = IDLE;
        end
      end
      SHIFT:   if (tick && half == 6'd35) state_n = GAP;
      GAP:     if (gap_cnt == GAP_W'(2 * DIV - 1)) state_n = cur_scan ? ACCUM : IDLE;
      // the period counts from the end of the gap to the next CS fall
      ACCUM:   state_n = (grp_done && nxt_wrap && period >= 16'd2) ? WAIT_PERIOD : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_cs     <= 1'b1;
      adc_clk    <= 1'b0;
      div_cnt    <= '0;
      half       <= '0;
      gap_cnt    <= '0;
      sr         <= '0;
      mosi       <= '0;
      cur_ch     <= '0;
      cur_scan   <= 1'b0;
      pend_vld   <= 1'b0;
      pend_ch    <= '0;
      mask       <= '0;
      period     <= '0;
      tmr        <= '0;
      ptr        <= '0;
      acc        <= '0;
      smp_cnt    <= '0;
      ovr        <= 1'b0;
      out_data_q <= '0;
      out_wr_q   <= 1'b0;
    end else begin
      if (tmr != '0) tmr <= tmr - 16'd1;

      if (host.in_wr) begin
        unique case (op)
          8'h01:   mask   <= host.in_data[CHANNELS-1:0];
          8'h02:   period <= host.in_data[15:0];
          8'h03:   mask   <= '0;
          default: ;
        endcase
      end

      if (start && !start_scan) pend_vld <= 1'b0;
      else if (cmd_single) begin
        pend_vld <= 1'b1;
        pend_ch  <= host.in_data[2:0];
      end

      if (start) begin
        adc_cs   <= 1'b0;
        adc_clk  <= 1'b0;
        div_cnt  <= '0;
        half     <= '0;
        gap_cnt  <= '0;
        cur_ch   <= start_ch;
        cur_scan <= start_scan;
        mosi     <= {3'b011, start_ch};
        if (start_scan) begin
          ptr <= scan_ch;
          if (!mask8[ptr]) begin
            acc     <= '0;
            smp_cnt <= '0;
          end
        end
      end else if (state == SHIFT) begin
        if (tick) begin
          div_cnt <= '0;
          half    <= half + 6'd1;
          adc_clk <= ~adc_clk;
          if (!adc_clk) sr   <= {sr[8:0], adc_do};   // rising edge: sample MISO
          else          mosi <= {mosi[4:0], 1'b0};   // falling edge: next MOSI bit
          if (half == 6'd35) adc_cs <= 1'b1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end else if (state == ACCUM) begin
        if (grp_done) begin
          acc     <= '0;
          smp_cnt <= '0;
          ptr     <= nxt_ch;
          if (nxt_wrap && period >= 16'd2) tmr <= period - 16'd2;
        end else begin
          acc     <= acc_sum;
          smp_cnt <= smp_cnt + SMP_W'(1);
        end
      end

      // result register: a result arriving while one is still held is dropped
      if (pub) begin
        if (!out_wr_q || host.out_ack) begin
          out_data_q <= {cur_scan, ovr, 3'b000, cur_ch, 6'b0, pub_res};
          out_wr_q   <= 1'b1;
          ovr        <= 1'b0;
        end else begin
          ovr <= 1'b1;
        end
      end else if (host.out_ack) begin
        out_wr_q <= 1'b0;
      end
    end
  end

  assign adc_di        = mosi[5];
  assign host.out_data = out_data_q;
  assign host.out_wr   = out_wr_q;
  assign busy          = pend_vld || !(state == IDLE || state == WAIT_PERIOD);
endmodule
